// File: rtl/mem_bus_pkg.sv
// Shared encodings and lane helpers for the memory bus controller.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Byte enables for one access; bit 3 is the most significant (big-endian lane 0).
   function automatic logic [3:0] be_gen(input size_e sz, input logic [1:0] a);
      logic [3:0] be;
      be = 4'b0000;
      case (sz)
         SZ_BYTE: be = 4'b1000 >> a;
         SZ_HALF: be = (a[1] == 1'b0) ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // True when the access size is legal at this byte offset.
   function automatic logic is_aligned(input size_e sz, input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (sz)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = (a[0] == 1'b0);
         SZ_WORD: ok = (a == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// RAM-side request/acknowledge bus of the memory controller.
interface mem_bus_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: byte enables, write-data replication and
// read-lane extraction with sign or zero extension.
module mem_lane_unit
   import mem_bus_pkg::*;
(
   input  size_e       sz,
   input  logic [1:0]  lane,
   input  logic        sgn,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);
   logic [7:0]  lane8;
   logic [15:0] lane16;

   // Byte enables and replicated store data for the access size.
   always_comb begin
      be        = be_gen(sz, lane);
      wdata_rep = 32'h0000_0000;
      case (sz)
         SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
         SZ_HALF: wdata_rep = {2{wdata[15:0]}};
         SZ_WORD: wdata_rep = wdata;
         default: wdata_rep = 32'h0000_0000;
      endcase
   end

   // Select the addressed lane of the RAM word and extend it to 32 bits.
   always_comb begin
      lane8     = 8'h00;
      lane16    = 16'h0000;
      rdata_ext = 32'h0000_0000;
      case (lane)
         2'b00:   lane8 = mem_rdata[31:24];
         2'b01:   lane8 = mem_rdata[23:16];
         2'b10:   lane8 = mem_rdata[15:8];
         default: lane8 = mem_rdata[7:0];
      endcase
      if (lane[1] == 1'b0) begin
         lane16 = mem_rdata[31:16];
      end else begin
         lane16 = mem_rdata[15:0];
      end
      case (sz)
         SZ_BYTE: rdata_ext = {{24{sgn & lane8[7]}}, lane8};
         SZ_HALF: rdata_ext = {{16{sgn & lane16[15]}}, lane16};
         SZ_WORD: rdata_ext = mem_rdata;
         default: rdata_ext = 32'h0000_0000;
      endcase
   end
endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-access controller: latches a CPU request, checks alignment, runs the
// req/ack handshake with the word RAM (with timeout) and returns MOC plus status.
// All outputs are flops, so each lags the state that produces it by one cycle.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic           Clk,
   input  logic           clr,
   input  logic           MOV,
   input  logic           R_W,
   input  logic [1:0]     op_type,
   input  logic           sgn,
   input  logic [31:0]    addr,
   input  logic [31:0]    wdata,
   output logic [31:0]    rdata,
   output logic           MOC,
   output logic           align_err,
   output logic           bus_err,
   mem_bus_ctrl_if.master mbus
);
   localparam logic [7:0] TMO_C = 8'(TIMEOUT);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   size_e             sz_q, sz_d;
   logic              sgn_q, sgn_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              aerr_q, aerr_d;
   logic              berr_q, berr_d;

   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              moc_q, moc_d;
   logic              align_err_q, align_err_d;
   logic              bus_err_q, bus_err_d;

   logic              start_s, aligned_s, ack_s, tmo_s;
   logic              stay_req_s, finish_s;
   logic [3:0]        be_s;
   logic [31:0]       wrep_s, rext_s;
   logic              addr_unused;

   // Only the low ADDR_W address bits reach the RAM.
   assign addr_unused = ^addr[31:ADDR_W];

   assign aligned_s  = is_aligned(size_e'(op_type), addr[1:0]);
   assign start_s    = (state_q == IDLE) && MOV;
   // An ack only counts once the request is actually visible to the RAM.
   assign ack_s      = (state_q == REQ) && mem_req_q && mbus.mem_ack;
   assign tmo_s      = (state_q == REQ) && !ack_s && (cnt_q == TMO_C);
   assign stay_req_s = (state_q == REQ) && (state_d == REQ);
   assign finish_s   = (state_q == DONE) && (state_d == IDLE);

   mem_lane_unit u_lane (
      .sz        (sz_q),
      .lane      (addr_q[1:0]),
      .sgn       (sgn_q),
      .wdata     (wdata_q),
      .mem_rdata (mbus.mem_rdata),
      .be        (be_s),
      .wdata_rep (wrep_s),
      .rdata_ext (rext_s)
   );

   // State register.
   always_ff @(posedge Clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept from IDLE, finish REQ on ack or timeout, leave DONE on MOV low.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!MOV) begin
               state_d = IDLE;
            end else if (aligned_s) begin
               state_d = REQ;
            end else begin
               state_d = DONE;
            end
         end
         REQ: begin
            if (ack_s || tmo_s) begin
               state_d = DONE;
            end else begin
               state_d = REQ;
            end
         end
         DONE: begin
            if (!MOV) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values: request latch, counter, flags and bus drive.
   always_comb begin
      if (start_s) begin
         we_d    = ~R_W;
         sz_d    = size_e'(op_type);
         sgn_d   = sgn;
         addr_d  = addr[ADDR_W-1:0];
         wdata_d = wdata;
      end else begin
         we_d    = we_q;
         sz_d    = sz_q;
         sgn_d   = sgn_q;
         addr_d  = addr_q;
         wdata_d = wdata_q;
      end

      if (stay_req_s) begin
         cnt_d = cnt_q + 8'd1;
      end else if (finish_s) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q;
      end

      if (start_s) begin
         aerr_d = ~aligned_s;
      end else if (finish_s) begin
         aerr_d = 1'b0;
      end else begin
         aerr_d = aerr_q;
      end

      if (tmo_s) begin
         berr_d = 1'b1;
      end else if (start_s || finish_s) begin
         berr_d = 1'b0;
      end else begin
         berr_d = berr_q;
      end

      // Request fields are driven only while the request stays open, so they are stable.
      if (stay_req_s) begin
         mem_req_d   = 1'b1;
         mem_we_d    = we_q;
         mem_addr_d  = addr_q[ADDR_W-1:2];
         mem_be_d    = be_s;
         mem_wdata_d = wrep_s;
      end else begin
         mem_req_d   = 1'b0;
         mem_we_d    = 1'b0;
         mem_addr_d  = {(ADDR_W-2){1'b0}};
         mem_be_d    = 4'b0000;
         mem_wdata_d = 32'h0000_0000;
      end

      if (ack_s && !we_q) begin
         rdata_d = rext_s;
      end else begin
         rdata_d = rdata_q;
      end

      // MOC rises at least once per DONE visit, then drops on the first MOV-low sample.
      if ((state_q == DONE) && (MOV || !moc_q)) begin
         moc_d = 1'b1;
      end else begin
         moc_d = 1'b0;
      end

      align_err_d = moc_d & aerr_q;
      bus_err_d   = moc_d & berr_q;
   end

   // Datapath and output registers.
   always_ff @(posedge Clk or negedge clr) begin
      if (!clr) begin
         we_q        <= 1'b0;
         sz_q        <= SZ_BYTE;
         sgn_q       <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= 32'h0000_0000;
         cnt_q       <= 8'd0;
         aerr_q      <= 1'b0;
         berr_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {(ADDR_W-2){1'b0}};
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'h0000_0000;
         rdata_q     <= 32'h0000_0000;
         moc_q       <= 1'b0;
         align_err_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         we_q        <= we_d;
         sz_q        <= sz_d;
         sgn_q       <= sgn_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         aerr_q      <= aerr_d;
         berr_q      <= berr_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         moc_q       <= moc_d;
         align_err_q <= align_err_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign mbus.mem_req   = mem_req_q;
   assign mbus.mem_we    = mem_we_q;
   assign mbus.mem_addr  = mem_addr_q;
   assign mbus.mem_be    = mem_be_q;
   assign mbus.mem_wdata = mem_wdata_q;
   assign rdata          = rdata_q;
   assign MOC            = moc_q;
   assign align_err      = align_err_q;
   assign bus_err        = bus_err_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases plus randomized operations
// compared against a size/offset arithmetic model of the access rules.
module tb_mem_bus_ctrl;
   localparam int ADDR_W = 9;
   localparam int TMO    = 15;

   logic        Clk;
   logic        clr;
   logic        MOV;
   logic        R_W;
   logic [1:0]  op_type;
   logic        sgn;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        MOC;
   logic        align_err;
   logic        bus_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rdata;

   mem_bus_ctrl_if #(.ADDR_W(ADDR_W)) mbus ();

   mem_bus_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
      .Clk       (Clk),
      .clr       (clr),
      .MOV       (MOV),
      .R_W       (R_W),
      .op_type   (op_type),
      .sgn       (sgn),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .MOC       (MOC),
      .align_err (align_err),
      .bus_err   (bus_err),
      .mbus      (mbus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   function automatic bit m_misaligned(input logic [1:0] ty, input logic [31:0] a);
      int n;
      if (ty == 2'd3) return 1'b1;
      n = 1 << ty;
      return (int'(a[1:0]) % n) != 0;
   endfunction

   function automatic logic [31:0] m_be(input logic [1:0] ty, input logic [31:0] a);
      int n;
      int off;
      logic [31:0] be;
      n = 1 << ty;
      off = int'(a[1:0]);
      be = 32'd0;
      for (int b = 0; b < 4; b++) begin
         if (b >= off && b < off + n) be[3-b] = 1'b1;
      end
      return be;
   endfunction

   function automatic logic [31:0] m_wrep(input logic [1:0] ty, input logic [31:0] wd);
      int n;
      logic [31:0] r;
      n = 1 << ty;
      r = 32'd0;
      for (int b = 0; b < 4; b++) begin
         r[31-8*b -: 8] = wd[8*(n-1-(b%n)) +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] ty, input logic sg,
                                          input logic [31:0] a, input logic [31:0] w);
      int n;
      int off;
      logic [63:0] v;
      logic [63:0] mask;
      n = 1 << ty;
      off = int'(a[1:0]);
      mask = (64'd1 << (8*n)) - 64'd1;
      v = ({32'd0, w} >> (8*(4-n-off))) & mask;
      if (sg && n < 4 && v[8*n-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete operation. dly>=0: ack that many cycles after mem_req is seen;
   // dly<0: never ack (timeout). hold keeps MOV high until MOC has been observed.
   task automatic run_op(input string tag, input logic rw, input logic [1:0] ty,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input logic [31:0] ramw, input bit hold);
      bit aerr;
      int waited;
      int n_req;
      aerr = m_misaligned(ty, a);
      MOV = 1'b1; R_W = rw; op_type = ty; sgn = sg; addr = a; wdata = wd;
      @(negedge Clk);
      if (!hold) MOV = 1'b0;
      // Scramble inputs: the controller must work from its latched copy.
      R_W = ~rw; op_type = 2'($urandom); sgn = ~sg; addr = $urandom; wdata = $urandom;
      check({tag, "_req_early"}, {31'd0, mbus.mem_req}, 32'd0);
      check({tag, "_moc_early"}, {31'd0, MOC}, 32'd0);
      @(negedge Clk);
      if (aerr) begin
         check({tag, "_noreq"}, {31'd0, mbus.mem_req}, 32'd0);
         check({tag, "_moc"}, {31'd0, MOC}, 32'd1);
         check({tag, "_align_err"}, {31'd0, align_err}, 32'd1);
         check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
         check({tag, "_rdata_keep"}, rdata, exp_rdata);
      end else begin
         check({tag, "_req_lat"}, {31'd0, mbus.mem_req}, 32'd1);
         waited = 0;
         while (!mbus.mem_req && waited < 50) begin
            @(negedge Clk);
            waited++;
         end
         check({tag, "_we"}, {31'd0, mbus.mem_we}, {31'd0, ~rw});
         check({tag, "_addr"}, {25'd0, mbus.mem_addr}, (a >> 2) & 32'h7F);
         check({tag, "_be"}, {28'd0, mbus.mem_be}, m_be(ty, a));
         check({tag, "_wdata"}, mbus.mem_wdata, m_wrep(ty, wd));
         if (dly >= 0) begin
            for (int i = 0; i < dly; i++) begin
               @(negedge Clk);
               check({tag, "_req_hold"}, {31'd0, mbus.mem_req}, 32'd1);
               check({tag, "_be_hold"}, {28'd0, mbus.mem_be}, m_be(ty, a));
            end
            mbus.mem_rdata = ramw;
            mbus.mem_ack = 1'b1;
            @(negedge Clk);
            mbus.mem_ack = 1'b0;
            mbus.mem_rdata = $urandom;
            check({tag, "_req_drop"}, {31'd0, mbus.mem_req}, 32'd0);
            check({tag, "_moc_wait"}, {31'd0, MOC}, 32'd0);
            @(negedge Clk);
            if (rw) exp_rdata = m_read(ty, sg, a, ramw);
            check({tag, "_moc"}, {31'd0, MOC}, 32'd1);
            check({tag, "_align_ok"}, {31'd0, align_err}, 32'd0);
            check({tag, "_bus_ok"}, {31'd0, bus_err}, 32'd0);
            check({tag, "_rdata"}, rdata, exp_rdata);
         end else begin
            n_req = 0;
            while (mbus.mem_req && n_req < 100) begin
               n_req++;
               @(negedge Clk);
            end
            check({tag, "_req_cycles"}, n_req, TMO);
            check({tag, "_moc_wait"}, {31'd0, MOC}, 32'd0);
            @(negedge Clk);
            check({tag, "_moc"}, {31'd0, MOC}, 32'd1);
            check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd1);
            check({tag, "_rdata_keep"}, rdata, exp_rdata);
         end
      end
      if (hold) begin
         // A stray ack while complete must change nothing.
         mbus.mem_rdata = $urandom;
         mbus.mem_ack = 1'b1;
         @(negedge Clk);
         mbus.mem_ack = 1'b0;
         check({tag, "_moc_held"}, {31'd0, MOC}, 32'd1);
         check({tag, "_aerr_held"}, {31'd0, align_err}, {31'd0, aerr});
         check({tag, "_berr_held"}, {31'd0, bus_err}, {31'd0, (!aerr && dly < 0)});
         check({tag, "_rdata_late_ack"}, rdata, exp_rdata);
         MOV = 1'b0;
         @(negedge Clk);
         check({tag, "_moc_clear"}, {31'd0, MOC}, 32'd0);
         check({tag, "_flags_clear"}, {30'd0, align_err, bus_err}, 32'd0);
      end else begin
         @(negedge Clk);
         check({tag, "_moc_pulse"}, {31'd0, MOC}, 32'd0);
      end
      @(negedge Clk);
   endtask

   initial begin
      logic [1:0] rty;
      logic       rrw;
      MOV = 1'b0; R_W = 1'b0; op_type = 2'b00; sgn = 1'b0;
      addr = 32'd0; wdata = 32'd0;
      mbus.mem_ack = 1'b0; mbus.mem_rdata = 32'd0;
      exp_rdata = 32'd0;
      clr = 1'b0;

      // Reset state.
      #12;
      check("rst_rdata", rdata, 32'd0);
      check("rst_moc", {31'd0, MOC}, 32'd0);
      check("rst_flags", {30'd0, align_err, bus_err}, 32'd0);
      check("rst_req", {31'd0, mbus.mem_req}, 32'd0);
      check("rst_bus", {mbus.mem_be, mbus.mem_addr, mbus.mem_we}, 32'd0);
      check("rst_wdata", mbus.mem_wdata, 32'd0);
      @(negedge Clk);
      clr = 1'b1;
      @(negedge Clk);

      // Directed cases.
      run_op("wrd_rd",   1'b1, 2'b10, 1'b0, 32'h14, 32'h0,        2,  32'hDEADBEEF, 1'b1);
      run_op("byte_sx",  1'b1, 2'b00, 1'b1, 32'h15, 32'h0,        0,  32'hDEADBEEF, 1'b0);
      run_op("byte_zx",  1'b1, 2'b00, 1'b0, 32'h15, 32'h0,        0,  32'hDEADBEEF, 1'b1);
      run_op("half_wr",  1'b0, 2'b01, 1'b0, 32'h06, 32'h1234ABCD, 1,  32'h0,        1'b1);
      run_op("rsvd",     1'b1, 2'b11, 1'b0, 32'h00, 32'h0,        0,  32'h0,        1'b1);
      run_op("wrd_mis",  1'b1, 2'b10, 1'b0, 32'h02, 32'h0,        0,  32'h0,        1'b0);
      run_op("half_rd",  1'b1, 2'b01, 1'b1, 32'h1FE, 32'h0,       3,  32'h00018234, 1'b0);
      run_op("timeout",  1'b1, 2'b10, 1'b0, 32'h40, 32'h0,        -1, 32'h0,        1'b1);
      run_op("tmo_wr",   1'b0, 2'b00, 1'b0, 32'h43, 32'h5A,       -1, 32'h0,        1'b0);

      // Asynchronous reset in the middle of a request, MOV held high throughout.
      MOV = 1'b1; R_W = 1'b1; op_type = 2'b10; sgn = 1'b0; addr = 32'h20; wdata = 32'd0;
      @(negedge Clk);
      @(negedge Clk);
      check("rstmid_req_up", {31'd0, mbus.mem_req}, 32'd1);
      #2 clr = 1'b0;
      #1;
      check("rstmid_req", {31'd0, mbus.mem_req}, 32'd0);
      check("rstmid_moc", {31'd0, MOC}, 32'd0);
      check("rstmid_rdata", rdata, 32'd0);
      exp_rdata = 32'd0;
      @(negedge Clk);
      clr = 1'b1;
      run_op("rst_restart", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'hCAFE0123, 1'b0);

      // Randomized operations.
      for (int k = 0; k < 24; k++) begin
         rty = 2'($urandom_range(0, 3));
         rrw = 1'($urandom_range(0, 1));
         run_op("rand", rrw, rty, 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
